fir_input_sequencer: RTL and testbench
======================================

# fir_input_sequencer

Front end and control sequencer for the 29-tap symmetric complex FIR datapath. Accepts one complex input sample per push and keeps the 29-deep sample window. Holds the 15 complex coefficients. Generates the per-sample three-phase `mux_sel` sequence plus the `partialProductAccumulate_valid` and `finalAccumulateRounding_en` strobes consumed by `fir_datapath`. Applies backpressure so that one sample is accepted at most every 3 cycles.

## Interface
Parameters:
- `MULT_LAT`, default 1: register stages inside `complexMultiplier`, from registered sum to valid `p_prod`. Legal range 0..4.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `PushIn`  in  1  input sample valid
- `SampI`, `SampQ`  in  24 each  input sample, 1.23 two's complement
- `StopIn`  out  1  backpressure; a sample is accepted only when `PushIn & !StopIn`
- `CoefWr`  in  1  coefficient write strobe
- `CoefAddr`  in  4  coefficient index 0..14; writes to 15 are ignored
- `CoefI`, `CoefQ`  in  27 each  coefficient data
- `win_i`, `win_q`  out  29*24 each  sample window; slice `[24*k +: 24]` is `samp[k]`; `samp[0]` is newest
- `coef_i`, `coef_q`  out  15*27 each  coefficient array; slice `[27*k +: 27]` is `coef[k]`
- `mux_sel`  out  2  phase select, values 0..2
- `partialProductAccumulate_valid`  out  1  accumulate strobe to the datapath
- `finalAccumulateRounding_en`  out  1  final-sum strobe to the datapath

## Operation
Reset values:
- Window and coefficient registers are all zero.
- `mux_sel`=0; both strobes are 0.
- State is IDLE.
- `StopIn`=0.

Window:
- On accept, at the clock edge: `samp[k+1]` <= `samp[k]` for k=0..27, and `samp[0]` <= {SampI,SampQ}.
- `samp[28]` is discarded.
- Without an accept, the window holds its value.

Coefficients:
- `CoefWr` writes `coef[CoefAddr]` at the edge.
- A write is legal at any time. A write during a computation takes effect at the next edge and is the caller's responsibility.

State machine:
- States are IDLE, P0, P1, P2. `mux_sel` = 0/1/2 in P0/P1/P2 and 0 in IDLE.
- IDLE: accept -> P0, otherwise stay.
- P0 -> P1 -> P2 unconditionally.
- P2: accept -> P0, otherwise -> IDLE.
- `StopIn` = (state==P0 or state==P1). It is combinational, so it is 0 in IDLE and P2.
- Overlap in P2 is safe. The datapath sums register at the same edge that shifts the window, so phase 2 uses the old window.

Strobe pipeline:
- A phase tag (valid, phase) enters a shift register of depth 1+MULT_LAT when the state is P0/P1/P2.
- At the tap output, a tag with phase 0 drives `partialProductAccumulate_valid`=0 (load).
- At the tap output, a tag with phase 1 or 2 drives `partialProductAccumulate_valid`=1.
- A phase-2 tag at the tap output sets `finalAccumulateRounding_en`=1 in the following cycle, for exactly one cycle.
- With no tag at the tap output, `partialProductAccumulate_valid`=0.

Other rules:
- A write with `CoefWr` and `CoefAddr`=15 has no effect.
- `PushIn` while `StopIn`=1 is ignored: no shift, no state change. The source must hold the sample.
- Reset mid-computation clears all state and tags. No `finalAccumulateRounding_en` is produced for the interrupted sample.

## Timing
Let the sample be accepted at the edge ending cycle 0.
- `mux_sel` = 0, 1, 2 in cycles 1, 2, 3.
- `partialProductAccumulate_valid` = 0, 1, 1 in cycles 2+MULT_LAT, 3+MULT_LAT, 4+MULT_LAT.
- `finalAccumulateRounding_en`=1 in cycle 5+MULT_LAT only.
- Latency from accept to `finalAccumulateRounding_en` is 5+MULT_LAT cycles.
- Maximum throughput is 1 sample per 3 cycles. Back-to-back samples accepted at cycles 0 and 3 give `finalAccumulateRounding_en` at cycles 5+MULT_LAT and 8+MULT_LAT.
- The next sample's phase-0 load coincides with the previous sample's `finalAccumulateRounding_en` cycle. This is legal because the datapath reads `sub_prod` before it is overwritten.
- `win_*` and `coef_*` are registered outputs. Every output except `StopIn` is registered.

## Test plan
- Reset check: assert `reset` asynchronously mid-cycle -> all outputs are 0 immediately, and window and coefficients read back as 0.
- Single push, MULT_LAT=1: SampI=0x100000, SampQ=0xF00000 at cycle 0 -> `samp[0]`={0x100000,0xF00000} from cycle 1.
  - `mux_sel` = 0,1,2 in cycles 1-3.
  - `partialProductAccumulate_valid` = 0,1,1 in cycles 3-5.
  - `finalAccumulateRounding_en` only in cycle 6.
- Continuous `PushIn` with 30 incrementing samples 1..30 -> accepts occur every 3rd cycle and `StopIn` follows the 0,1,1 pattern.
  - After 30 accepts, `samp[0]`=30 and `samp[28]`=2.
  - 30 `finalAccumulateRounding_en` pulses, spaced 3 cycles apart.
- Coefficient write: write `coef[k]`=k+1 for k=0..14, then a write with CoefAddr=15 and 0x7FFFFFF -> the array reads 1..15 with nothing else changed.
- Reset in P1: push, then assert `reset` in cycle 2 -> no `finalAccumulateRounding_en`. After release, state is IDLE and `StopIn`=0.
- MULT_LAT=3 build: single push -> the accumulate strobes land in cycles 5-7 and `finalAccumulateRounding_en` lands in cycle 8.

Source files
------------

// File: rtl/fir_input_sequencer_if.sv
// rtl/fir_input_sequencer_if.sv - sample push and coefficient write bus for the FIR input sequencer
interface fir_input_sequencer_if;
   logic        PushIn;
   logic [23:0] SampI;
   logic [23:0] SampQ;
   logic        StopIn;
   logic        CoefWr;
   logic [3:0]  CoefAddr;
   logic [26:0] CoefI;
   logic [26:0] CoefQ;

   modport master (
      output PushIn, SampI, SampQ, CoefWr, CoefAddr, CoefI, CoefQ,
      input  StopIn
   );

   modport slave (
      input  PushIn, SampI, SampQ, CoefWr, CoefAddr, CoefI, CoefQ,
      output StopIn
   );
endinterface

// File: rtl/fir_input_sequencer.sv
// rtl/fir_input_sequencer.sv - sample window, coefficient store and three-phase strobe sequencer
module fir_input_sequencer #(
   parameter int MULT_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   fir_input_sequencer_if.slave bus,
   output logic [29*24-1:0]     win_i,
   output logic [29*24-1:0]     win_q,
   output logic [15*27-1:0]     coef_i,
   output logic [15*27-1:0]     coef_q,
   output logic [1:0]           mux_sel,
   output logic                 partialProductAccumulate_valid,
   output logic                 finalAccumulateRounding_en
);
   localparam int DEPTH = 1 + MULT_LAT;

   typedef enum logic [1:0] {IDLE, P0, P1, P2} state_t;

   state_t             state_q, state_d;
   logic [29*24-1:0]   win_i_q, win_i_d, win_q_q, win_q_d;
   logic [15*27-1:0]   coef_i_q, coef_i_d, coef_q_q, coef_q_d;
   logic [1:0]         mux_sel_q, mux_sel_d;
   logic               pav_q, pav_d;
   logic               fre_q, fre_d;
   logic [DEPTH-1:0]   tag_v_q, tag_v_d;
   logic [1:0]         tag_p_q [DEPTH];
   logic [1:0]         tag_p_d [DEPTH];
   logic               stop;
   logic               accept;

   // A sample may only enter while the previous one is in its last phase or idle.
   assign stop   = (state_q == P0) || (state_q == P1);
   assign accept = bus.PushIn && !stop;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = P0;
         P0:      state_d = P1;
         P1:      state_d = P2;
         P2:      state_d = accept ? P0 : IDLE;
         default: state_d = IDLE;
      endcase

      case (state_d)
         P1:      mux_sel_d = 2'd1;
         P2:      mux_sel_d = 2'd2;
         default: mux_sel_d = 2'd0;
      endcase

      win_i_d = win_i_q;
      win_q_d = win_q_q;
      if (accept) begin
         win_i_d = {win_i_q[28*24-1:0], bus.SampI};
         win_q_d = {win_q_q[28*24-1:0], bus.SampQ};
      end

      coef_i_d = coef_i_q;
      coef_q_d = coef_q_q;
      if (bus.CoefWr && (bus.CoefAddr != 4'd15)) begin
         coef_i_d[27*int'(bus.CoefAddr) +: 27] = bus.CoefI;
         coef_q_d[27*int'(bus.CoefAddr) +: 27] = bus.CoefQ;
      end

      // Phase tags track the multiplier latency so strobes line up with p_prod.
      tag_v_d    = '0;
      tag_p_d    = '{default: 2'd0};
      tag_v_d[0] = (state_q != IDLE);
      tag_p_d[0] = (state_q == P1) ? 2'd1 : (state_q == P2) ? 2'd2 : 2'd0;
      for (int i = 1; i < DEPTH; i++) begin
         tag_v_d[i] = tag_v_q[i-1];
         tag_p_d[i] = tag_p_q[i-1];
      end

      pav_d = tag_v_d[DEPTH-1] && (tag_p_d[DEPTH-1] != 2'd0);
      fre_d = tag_v_q[DEPTH-1] && (tag_p_q[DEPTH-1] == 2'd2);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         win_i_q   <= '0;
         win_q_q   <= '0;
         coef_i_q  <= '0;
         coef_q_q  <= '0;
         mux_sel_q <= 2'd0;
         pav_q     <= 1'b0;
         fre_q     <= 1'b0;
         tag_v_q   <= '0;
         tag_p_q   <= '{default: 2'd0};
      end else begin
         state_q   <= state_d;
         win_i_q   <= win_i_d;
         win_q_q   <= win_q_d;
         coef_i_q  <= coef_i_d;
         coef_q_q  <= coef_q_d;
         mux_sel_q <= mux_sel_d;
         pav_q     <= pav_d;
         fre_q     <= fre_d;
         tag_v_q   <= tag_v_d;
         tag_p_q   <= tag_p_d;
      end
   end

   assign bus.StopIn                     = stop;
   assign win_i                          = win_i_q;
   assign win_q                          = win_q_q;
   assign coef_i                         = coef_i_q;
   assign coef_q                         = coef_q_q;
   assign mux_sel                        = mux_sel_q;
   assign partialProductAccumulate_valid = pav_q;
   assign finalAccumulateRounding_en     = fre_q;
endmodule

// File: tb/tb_fir_input_sequencer.sv
// tb/tb_fir_input_sequencer.sv - randomized model-based bench for fir_input_sequencer at MULT_LAT 1 and 3
module tb_fir_input_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fir_input_sequencer_if bus1 ();
   fir_input_sequencer_if bus3 ();

   assign bus3.PushIn   = bus1.PushIn;
   assign bus3.SampI    = bus1.SampI;
   assign bus3.SampQ    = bus1.SampQ;
   assign bus3.CoefWr   = bus1.CoefWr;
   assign bus3.CoefAddr = bus1.CoefAddr;
   assign bus3.CoefI    = bus1.CoefI;
   assign bus3.CoefQ    = bus1.CoefQ;

   logic [695:0] win_i1, win_q1, win_i3, win_q3;
   logic [404:0] coef_i1, coef_q1, coef_i3, coef_q3;
   logic [1:0]   mux1, mux3;
   logic         pav1, pav3, fre1, fre3;

   fir_input_sequencer #(.MULT_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1),
      .win_i(win_i1), .win_q(win_q1), .coef_i(coef_i1), .coef_q(coef_q1),
      .mux_sel(mux1), .partialProductAccumulate_valid(pav1), .finalAccumulateRounding_en(fre1)
   );

   fir_input_sequencer #(.MULT_LAT(3)) dut3 (
      .clk(clk), .reset(reset), .bus(bus3),
      .win_i(win_i3), .win_q(win_q3), .coef_i(coef_i3), .coef_q(coef_q3),
      .mux_sel(mux3), .partialProductAccumulate_valid(pav3), .finalAccumulateRounding_en(fre3)
   );

   logic [23:0] m_si [29];
   logic [23:0] m_sq [29];
   logic [26:0] m_ci [15];
   logic [26:0] m_cq [15];
   int          acc_q [$];
   int          cyc, n_chk, n_pass, n_fre;

   task automatic chk(input string tag, input logic [695:0] got, input logic [695:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // True when some accepted sample lies lo..hi cycles in the past.
   function automatic bit ago(input int c, input int lo, input int hi);
      foreach (acc_q[i]) if ((c - acc_q[i] >= lo) && (c - acc_q[i] <= hi)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] exp_mux(input int c);
      foreach (acc_q[i]) if ((c - acc_q[i] >= 1) && (c - acc_q[i] <= 3)) return 2'(c - acc_q[i] - 1);
      return 2'd0;
   endfunction

   function automatic logic [695:0] pack_win(input bit q);
      logic [695:0] v = '0;
      for (int k = 0; k < 29; k++) v[24*k +: 24] = q ? m_sq[k] : m_si[k];
      return v;
   endfunction

   function automatic logic [695:0] pack_coef(input bit q);
      logic [695:0] v = '0;
      for (int k = 0; k < 15; k++) v[27*k +: 27] = q ? m_cq[k] : m_ci[k];
      return v;
   endfunction

   task automatic check_dut(input string nm, input int lat, input logic [1:0] mux, input logic pav,
                            input logic fre, input logic stop, input logic [695:0] wi,
                            input logic [695:0] wq, input logic [404:0] ci, input logic [404:0] cq);
      chk({nm, ".mux_sel"}, mux, exp_mux(cyc));
      chk({nm, ".pav"}, pav, ago(cyc, 3 + lat, 4 + lat));
      chk({nm, ".fre"}, fre, ago(cyc, 5 + lat, 5 + lat));
      chk({nm, ".StopIn"}, stop, ago(cyc, 1, 2));
      chk({nm, ".win_i"}, wi, pack_win(1'b0));
      chk({nm, ".win_q"}, wq, pack_win(1'b1));
      chk({nm, ".coef_i"}, ci, pack_coef(1'b0));
      chk({nm, ".coef_q"}, cq, pack_coef(1'b1));
   endtask

   task automatic clear_model();
      acc_q.delete();
      for (int k = 0; k < 29; k++) begin m_si[k] = '0; m_sq[k] = '0; end
      for (int k = 0; k < 15; k++) begin m_ci[k] = '0; m_cq[k] = '0; end
   endtask

   task automatic cycle(input bit push, input logic [23:0] si, input logic [23:0] sq, input bit cw,
                        input logic [3:0] ca, input logic [26:0] ci, input logic [26:0] cq,
                        output bit acc);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_dut("L1", 1, mux1, pav1, fre1, bus1.StopIn, win_i1, win_q1, coef_i1, coef_q1);
      check_dut("L3", 3, mux3, pav3, fre3, bus3.StopIn, win_i3, win_q3, coef_i3, coef_q3);
      if (fre1) n_fre++;
      bus1.PushIn   = push;
      bus1.SampI    = si;
      bus1.SampQ    = sq;
      bus1.CoefWr   = cw;
      bus1.CoefAddr = ca;
      bus1.CoefI    = ci;
      bus1.CoefQ    = cq;
      acc = push && !reset && !ago(cyc, 1, 2);
      if (acc) begin
         acc_q.push_back(cyc);
         for (int k = 28; k > 0; k--) begin m_si[k] = m_si[k-1]; m_sq[k] = m_sq[k-1]; end
         m_si[0] = si;
         m_sq[0] = sq;
      end
      if (cw && !reset && (ca != 4'd15)) begin m_ci[ca] = ci; m_cq[ca] = cq; end
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, '0, '0, '0, a);
   endtask

   // Asserts reset away from the clock edge and expects every output to clear at once.
   task automatic hit_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst.mux1", mux1, 0);
      chk("rst.pav1", pav1, 0);
      chk("rst.fre1", fre1, 0);
      chk("rst.stop1", bus1.StopIn, 0);
      chk("rst.win_i1", win_i1, 0);
      chk("rst.coef_q1", coef_q1, 0);
      chk("rst.fre3", fre3, 0);
      chk("rst.win_q3", win_q3, 0);
      chk("rst.coef_i3", coef_i3, 0);
      clear_model();
   endtask

   initial begin
      bit a;
      int idx;
      reset = 1'b1;
      bus1.PushIn = 1'b0; bus1.SampI = '0; bus1.SampQ = '0;
      bus1.CoefWr = 1'b0; bus1.CoefAddr = '0; bus1.CoefI = '0; bus1.CoefQ = '0;
      cyc = 0; n_chk = 0; n_pass = 0; n_fre = 0;
      clear_model();
      idle(2);
      reset = 1'b0;
      idle(2);

      cycle(1'b1, 24'h100000, 24'hF00000, 1'b0, '0, '0, '0, a);
      chk("single.accept", a, 1);
      idle(1);
      chk("single.samp0_i", win_i1[23:0], 24'h100000);
      chk("single.samp0_q", win_q1[23:0], 24'hF00000);
      idle(10);

      for (int k = 0; k < 15; k++)
         cycle(1'b0, '0, '0, 1'b1, 4'(k), 27'(k + 1), 27'($urandom()), a);
      cycle(1'b0, '0, '0, 1'b1, 4'd15, 27'h7FFFFFF, 27'h7FFFFFF, a);
      idle(1);
      for (int k = 0; k < 15; k++) chk("coef.readback", coef_i1[27*k +: 27], 27'(k + 1));

      idx = 1;
      n_fre = 0;
      for (int t = 0; (t < 200) && (idx <= 30); t++) begin
         cycle(1'b1, 24'(idx), 24'(idx), 1'b0, '0, '0, '0, a);
         if (a) idx++;
      end
      chk("cont.accepts", 32'(idx), 31);
      idle(1);
      chk("cont.samp0", win_i1[23:0], 30);
      chk("cont.samp28", win_i1[28*24 +: 24], 2);
      idle(12);
      chk("cont.fre_count", 32'(n_fre), 30);

      for (int t = 0; t < 300; t++)
         cycle(1'($urandom_range(0, 1)), 24'($urandom()), 24'($urandom()),
               ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
               27'($urandom()), 27'($urandom()), a);
      idle(12);

      cycle(1'b1, 24'h0ABCDE, 24'h123456, 1'b0, '0, '0, '0, a);
      chk("p1rst.accept", a, 1);
      idle(2);
      chk("p1rst.mux_sel", mux1, 1);
      hit_reset();
      idle(2);
      reset = 1'b0;
      n_fre = 0;
      idle(12);
      chk("p1rst.no_fre", 32'(n_fre), 0);
      cycle(1'b1, 24'h7FFFFF, 24'h800000, 1'b0, '0, '0, '0, a);
      chk("p1rst.idle_accept", a, 1);
      idle(12);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
